// File: rtl/ece453_led_sequencer_if.sv
// Bundle of control inputs and status outputs for ece453_led_sequencer.
// The master side (for example a bench or SoC wrapper) drives the controls and watches the status.
// The slave side is the sequencer itself.
//   fsm_enable, button, direction, wrap_mode : controls driven by the master
//   led_out, current_state, position, step_pulse : status driven by the slave
interface ece453_led_sequencer_if #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned POS_W    = $clog2(NUM_LEDS)
);
  logic                fsm_enable;
  logic                button;
  logic                direction;
  logic                wrap_mode;
  logic [NUM_LEDS-1:0] led_out;
  logic [1:0]          current_state;
  logic [POS_W-1:0]    position;
  logic                step_pulse;

  modport master (
    output fsm_enable, button, direction, wrap_mode,
    input  led_out, current_state, position, step_pulse
  );

  modport slave (
    input  fsm_enable, button, direction, wrap_mode,
    output led_out, current_state, position, step_pulse
  );
endinterface

// File: rtl/ece453_led_sequencer.sv
// One-hot LED sequencer with START/RUN/HOLD control and a prescaled stepper.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : ece453_led_sequencer_if.slave
//           in : fsm_enable, button, direction (1 = left/increment), wrap_mode
//           out: led_out (one-hot or zero), current_state (START=0, RUN=1, HOLD=2),
//                position, step_pulse (one cycle per position change)
// Optional build macro ECE453_LED_SEQ_BOUNCE_EN: with wrap_mode = 0, an end
// reverses the direction so the light ping-pongs. Without it, the light saturates at the end.
module ece453_led_sequencer #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned POS_W    = $clog2(NUM_LEDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  ece453_led_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              state_q;
  logic [POS_W-1:0]    pos_q;
  logic [NUM_LEDS-1:0] led_q;
  logic                pulse_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                eff_left;
  logic                at_end;
  logic [POS_W-1:0]    step_pos;
  logic                step_ok;

`ifdef ECE453_LED_SEQ_BOUNCE_EN
  logic rev_q;
  logic step_flip;
  assign eff_left = bus.direction ^ rev_q;
`else
  assign eff_left = bus.direction;
`endif

  // The end we are about to run into depends on the effective direction.
  assign at_end = eff_left ? (pos_q == POS_MAX) : (pos_q == '0);

  // Candidate position for the next step, and whether that step is allowed at all
  always_comb begin
    step_pos = pos_q;
    step_ok  = 1'b1;
`ifdef ECE453_LED_SEQ_BOUNCE_EN
    step_flip = 1'b0;
`endif
    if (!at_end) begin
      step_pos = eff_left ? POS_W'(pos_q + 1'b1) : POS_W'(pos_q - 1'b1);
    end else if (bus.wrap_mode) begin
      step_pos = eff_left ? '0 : POS_MAX;
    end else begin
`ifdef ECE453_LED_SEQ_BOUNCE_EN
      // Bounce: turn around and take the step in the opposite direction.
      step_flip = 1'b1;
      step_pos  = eff_left ? POS_W'(pos_q - 1'b1) : POS_W'(pos_q + 1'b1);
`else
      step_ok = 1'b0;
`endif
    end
  end

  // State machine, prescaler and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_START;
      pos_q   <= '0;
      led_q   <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
`ifdef ECE453_LED_SEQ_BOUNCE_EN
      rev_q   <= 1'b0;
`endif
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_START: begin
          pos_q <= '0;
          led_q <= '0;
          cnt_q <= '0;
          if (bus.fsm_enable) begin
            state_q <= ST_RUN;
            led_q   <= NUM_LEDS'(1);
          end
        end
        ST_RUN: begin
          if (!bus.fsm_enable) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
          end else if (!bus.button) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_TOP) begin
            cnt_q <= '0;
            if (step_ok) begin
              pos_q   <= step_pos;
              led_q   <= NUM_LEDS'(1) << step_pos;
              pulse_q <= 1'b1;
            end
`ifdef ECE453_LED_SEQ_BOUNCE_EN
            rev_q <= rev_q ^ step_flip;
`endif
          end else begin
            cnt_q <= CNT_W'(cnt_q + 1'b1);
          end
        end
        ST_HOLD: begin
          cnt_q <= '0;
          if (bus.fsm_enable) state_q <= ST_RUN;
        end
        default: state_q <= ST_START;
      endcase
    end
  end

  assign bus.led_out       = led_q;
  assign bus.current_state = state_q;
  assign bus.position      = pos_q;
  assign bus.step_pulse    = pulse_q;

endmodule

// File: tb/tb_ece453_led_sequencer.sv
// Bench for ece453_led_sequencer.
// It drives two instances from the same controls: dut0 uses TICK_DIV=1 and dut1 uses TICK_DIV=3.
// The bench covers reset, stepping, wrap, hold and prescaler cases, followed by a randomized run checked against a model.
module tb_ece453_led_sequencer;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, btn = 1'b0, dir = 1'b0, wrap = 1'b0;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ece453_led_sequencer_if #(.NUM_LEDS(N), .POS_W(3)) if0 ();
  ece453_led_sequencer_if #(.NUM_LEDS(N), .POS_W(3)) if1 ();

  assign if0.fsm_enable = en;
  assign if0.button     = btn;
  assign if0.direction  = dir;
  assign if0.wrap_mode  = wrap;
  assign if1.fsm_enable = en;
  assign if1.button     = btn;
  assign if1.direction  = dir;
  assign if1.wrap_mode  = wrap;

  ece453_led_sequencer #(.NUM_LEDS(N), .TICK_DIV(1), .POS_W(3)) dut0 (
    .clk(clk), .reset(rst), .bus(if0.slave));
  ece453_led_sequencer #(.NUM_LEDS(N), .TICK_DIV(3), .POS_W(3)) dut1 (
    .clk(clk), .reset(rst), .bus(if1.slave));

  typedef struct {
    bit   rst, en, btn, dir, wrap;
    int   led, pos, st, pulse;
  } vec_t;

  // Behavioural model: the state is kept as plain integers.
  typedef struct {
    int st;
    int pos;
    int cnt;
    bit flag;
    int pulse;
  } mdl_t;

  function automatic mdl_t mstep(mdl_t m, bit r, bit e, bit b, bit d, bit w, int tdiv);
    mdl_t n = m;
    int delta, np;
    n.pulse = 0;
    if (r) begin
      n.st = 0; n.pos = 0; n.cnt = 0; n.flag = 0;
      return n;
    end
    case (m.st)
      0: if (e) begin n.st = 1; n.pos = 0; n.cnt = 0; end
      1: begin
        if (!e) begin n.st = 2; n.cnt = 0; end
        else if (!b) n.cnt = 0;
        else if (m.cnt + 1 < tdiv) n.cnt = m.cnt + 1;
        else begin
          n.cnt = 0;
          delta = (d ^ m.flag) ? 1 : -1;
          np = m.pos + delta;
          if (np >= 0 && np < N) begin n.pos = np; n.pulse = 1; end
          else if (w) begin n.pos = (np + N) % N; n.pulse = 1; end
          else begin
`ifdef ECE453_LED_SEQ_BOUNCE_EN
            n.flag = !m.flag; n.pos = m.pos - delta; n.pulse = 1;
`endif
          end
        end
      end
      default: begin n.cnt = 0; if (e) n.st = 1; end
    endcase
    return n;
  endfunction

  function automatic int mled(mdl_t m);
    return (m.st == 0) ? 0 : (1 << m.pos);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit b, input bit d, input bit w);
    rst = r; en = e; btn = b; dir = d; wrap = w;
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string nm, input int led, input int pos, input int st, input int pulse);
    chk({nm, ".led"},   32'(if0.led_out),       led);
    chk({nm, ".pos"},   32'(if0.position),      pos);
    chk({nm, ".state"}, 32'(if0.current_state), st);
    chk({nm, ".pulse"}, 32'(if0.step_pulse),    pulse);
  endtask

  vec_t tbl[12];
  mdl_t m0, m1;

  function automatic vec_t mk(bit r, bit e, bit b, bit d, bit w, int led, int pos, int st, int p);
    vec_t v;
    v.rst = r; v.en = e; v.btn = b; v.dir = d; v.wrap = w;
    v.led = led; v.pos = pos; v.st = st; v.pulse = p;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 1, 1, 8'h01, 0, 1, 0);
    tbl[4]  = mk(0, 1, 1, 1, 1, 8'h02, 1, 1, 1);
    tbl[5]  = mk(0, 1, 1, 1, 1, 8'h04, 2, 1, 1);
    tbl[6]  = mk(0, 1, 1, 1, 1, 8'h08, 3, 1, 1);
    tbl[7]  = mk(0, 1, 0, 1, 1, 8'h08, 3, 1, 0);
    tbl[8]  = mk(0, 1, 1, 0, 1, 8'h04, 2, 1, 1);
    tbl[9]  = mk(0, 0, 1, 0, 1, 8'h04, 2, 2, 0);
    tbl[10] = mk(0, 1, 1, 0, 1, 8'h04, 2, 1, 0);
    tbl[11] = mk(0, 1, 1, 0, 1, 8'h02, 1, 1, 1);

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].btn, tbl[i].dir, tbl[i].wrap);
      chk0($sformatf("tbl%0d", i), tbl[i].led, tbl[i].pos, tbl[i].st, tbl[i].pulse);
    end

    // Wrap at both ends, then a blocked or bounced step at the left end.
    cyc(0, 1, 1, 0, 1); chk0("wrapR_to0", 8'h01, 0, 1, 1);
    cyc(0, 1, 1, 0, 1); chk0("wrapR_to7", 8'h80, 7, 1, 1);
    cyc(0, 1, 1, 1, 1); chk0("wrapL_to0", 8'h01, 0, 1, 1);
    cyc(0, 1, 1, 0, 1); chk0("wrapR_again", 8'h80, 7, 1, 1);
`ifdef ECE453_LED_SEQ_BOUNCE_EN
    cyc(0, 1, 1, 1, 0); chk0("bounce_at7", 8'h40, 6, 1, 1);
`else
    cyc(0, 1, 1, 1, 0); chk0("sat_at7", 8'h80, 7, 1, 0);
    cyc(0, 1, 1, 1, 0); chk0("sat_at7_b", 8'h80, 7, 1, 0);
`endif

    // Hold at position 5, resume, then reset in the middle of a step.
    cyc(1, 0, 0, 1, 1); chk0("rst_b", 8'h00, 0, 0, 0);
    cyc(0, 1, 0, 1, 1); chk0("run_b", 8'h01, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 1);
    chk0("at5", 8'h20, 5, 1, 1);
    cyc(0, 0, 1, 1, 1); chk0("hold5", 8'h20, 5, 2, 0);
    cyc(0, 0, 1, 1, 1); chk0("hold5_b", 8'h20, 5, 2, 0);
    cyc(0, 1, 0, 1, 1); chk0("resume5", 8'h20, 5, 1, 0);
    cyc(0, 1, 1, 1, 1); chk0("step6", 8'h40, 6, 1, 1);
    cyc(1, 1, 1, 1, 1); chk0("rst_midstep", 8'h00, 0, 0, 0);

    // dut1 with TICK_DIV=3: holding the button for 9 cycles should give steps on cycles 3, 6 and 9.
    cyc(0, 1, 0, 1, 1);
    chk("t3.state", 32'(if1.current_state), 1);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 1, 1, 1);
      chk($sformatf("t3.pulse%0d", i), 32'(if1.step_pulse), (i % 3 == 2) ? 1 : 0);
      chk($sformatf("t3.pos%0d", i),   32'(if1.position),   (i + 1) / 3);
    end

`ifdef ECE453_LED_SEQ_BOUNCE_EN
    cyc(1, 0, 0, 1, 1);
    cyc(0, 1, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 1, 1);
    chk0("bnc_start6", 8'h40, 6, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 1, 0);
      chk0($sformatf("bnc%0d", i), 1 << (i == 0 ? 7 : 7 - i), (i == 0 ? 7 : 7 - i), 1, 1);
    end
`endif

    // Randomized run compared against the model for both instances.
    m0 = '{default: 0};
    m1 = '{default: 0};
    cyc(1, 0, 0, 0, 0);
    m0 = mstep(m0, 1, 0, 0, 0, 0, 1);
    m1 = mstep(m1, 1, 0, 0, 0, 0, 3);
    begin
      bit r, e, b, d, w;
      d = 1'b1; w = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        r = ($urandom % 64) == 0;
        e = ($urandom % 10) != 0;
        b = ($urandom % 5) != 0;
        if (($urandom % 8) == 0) d = !d;
        if (($urandom % 10) == 0) w = !w;
        m0 = mstep(m0, r, e, b, d, w, 1);
        m1 = mstep(m1, r, e, b, d, w, 3);
        cyc(r, e, b, d, w);
        chk0($sformatf("rnd%0d", i), mled(m0), m0.pos, m0.st, m0.pulse);
        chk($sformatf("rnd%0d.d1led", i),   32'(if1.led_out),       mled(m1));
        chk($sformatf("rnd%0d.d1pos", i),   32'(if1.position),      m1.pos);
        chk($sformatf("rnd%0d.d1state", i), 32'(if1.current_state), m1.st);
        chk($sformatf("rnd%0d.d1pulse", i), 32'(if1.step_pulse),    m1.pulse);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ece453_led_sequencer.md
ECE453_LED_SEQUENCER -- requirements
Module: ece453_led_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 8, number of one-hot LED outputs (legal 2..16).
REQ-002 The block SHALL have parameter TICK_DIV, default 1, clock cycles per position step while stepping (legal 1..255).
REQ-003 The block SHALL have parameter POS_W, default $clog2(NUM_LEDS), width of the position output.
REQ-004 The block SHALL have the port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have the port fsm_enable, input, 1 bit; 1 runs the sequencer, 0 stops it.
REQ-007 The block SHALL have the port button, input, 1 bit; while 1 in RUN, the position steps.
REQ-008 The block SHALL have the port direction, input, 1 bit; 1 = LEFT (position increments), 0 = RIGHT (position decrements).
REQ-009 The block SHALL have the port wrap_mode, input, 1 bit; 1 = wrap at ends, 0 = end behaviour per REQ-020.
REQ-010 The block SHALL have the port led_out, output, NUM_LEDS bits, one-hot lit LED, or all zero.
REQ-011 The block SHALL have the port current_state, output, 2 bits, encoded as START=2'd0, RUN=2'd1, HOLD=2'd2.
REQ-012 The block SHALL have the port position, output, POS_W bits, index of the lit LED.
REQ-013 The block SHALL have the port step_pulse, output, 1 bit, high for one cycle in the cycle after each position change.

Function
REQ-014 All outputs SHALL be registered; a qualifying input at edge N SHALL be visible on the outputs after edge N.
REQ-015 START: led_out = 0, position = 0; the block SHALL go to RUN when fsm_enable = 1, with position = 0 and led_out = 1.
REQ-016 RUN: led_out SHALL equal 1 << position.
REQ-017 RUN with fsm_enable = 0 SHALL go to HOLD; position and led_out are retained, and no step occurs that cycle.
REQ-018 HOLD with fsm_enable = 1 SHALL go to RUN, resuming from the retained position; HOLD never returns to START except on reset.
REQ-019 Prescaler: an 8-bit counter SHALL clear on entry to RUN, in HOLD, and whenever button = 0. In RUN with button = 1, it counts up. At TICK_DIV-1 a step occurs and the counter clears. With TICK_DIV = 1, a step occurs every cycle.
REQ-020 End handling:
- Stepping past NUM_LEDS-1 (LEFT) or past 0 (RIGHT) with wrap_mode = 1 SHALL wrap to 0 or to NUM_LEDS-1 respectively.
- With wrap_mode = 0, the position SHALL hold at the end; no step_pulse is raised for that blocked step.
REQ-021 A direction or wrap_mode change SHALL take effect at the next step; it does not reset the prescaler.
REQ-022 Priority, highest first: reset, fsm_enable = 0, step.

Reset
REQ-023 reset = 1 at a rising edge SHALL force the block to START from any state, including mid-step, on the next cycle.
REQ-024 On reset the outputs SHALL be: led_out = 0, position = 0, step_pulse = 0, current_state = START; the prescaler and bounce flag SHALL also clear.

Configuration
REQ-025 Macro ECE453_LED_SEQ_BOUNCE_EN defined: with wrap_mode = 0, reaching an end SHALL toggle an internal reverse flag. The effective direction is direction XOR flag, so the position ping-pongs, and each bounce step raises step_pulse.
REQ-026 Macro ECE453_LED_SEQ_BOUNCE_EN undefined: no reverse flag exists, and wrap_mode = 0 saturates per REQ-020.

Verification
REQ-027 Scenario, NUM_LEDS=8, TICK_DIV=1: reset 2 cycles, then release -> START, led_out=8'h00, position=0.
REQ-028 Scenario: fsm_enable=1 for 1 cycle -> RUN, led_out=8'h01; then button=1, direction=1 for 3 cycles -> led_out 8'h02, 8'h04, 8'h08, with step_pulse high each cycle.
REQ-029 Scenario: position=7, wrap_mode=1, direction=1, one step -> position=0, led_out=8'h01. With wrap_mode=0 and the macro undefined -> position stays 7, step_pulse=0.
REQ-030 Scenario: TICK_DIV=3, button held 9 cycles -> exactly 3 steps, on cycles 3, 6 and 9.
REQ-031 Scenario: fsm_enable=0 at position 5 -> HOLD, led_out=8'h20 retained; fsm_enable=1 -> RUN at position 5; reset during RUN -> START, led_out=0 next cycle.
REQ-032 Scenario with ECE453_LED_SEQ_BOUNCE_EN defined: wrap_mode=0, direction=1, start at 6, 4 steps -> positions 7, 6, 5, 4.
